nios_sys_irq_ctrl: RTL



---
 rtl/nios_sys_irq_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/nios_sys_irq_ctrl.sv
// Avalon-MM interrupt controller: edge/level capture, mask, force, priority vector, tick count.
// Optional macro IRQ_CTRL_SYNC_EN adds a two-flop input synchroniser ahead of irq_s.
module nios_sys_irq_ctrl #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             irq
);

`ifdef IRQ_CTRL_SYNC_EN
  localparam int ARM_W = 4;
`else
  localparam int ARM_W = 2;
`endif

  logic [N_IRQ-1:0] irq_src;
  logic [N_IRQ-1:0] irq_s, irq_d;
  logic [N_IRQ-1:0] pend, mask, edge_sel;
  logic [N_IRQ-1:0] rise, eff_pend, act;
  logic [N_IRQ-1:0] wdata_n, clr_bits, force_bits;
  logic [15:0]      tick_count;
  logic [ARM_W-1:0] arm;
  logic             wr;
  logic [3:0]       vec_idx;
  logic [15:0]      rd_mux;
  logic             unused_wdata;

`ifdef IRQ_CTRL_SYNC_EN
  logic [N_IRQ-1:0] sync_a, sync_b;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= irq_in;
      sync_b <= sync_a;
    end
  end

  assign irq_src = sync_b;
`else
  assign irq_src = irq_in;
`endif

  assign wr           = chipselect & ~write_n;
  assign wdata_n      = writedata[N_IRQ-1:0];
  assign unused_wdata = ^writedata[15:N_IRQ];
  assign clr_bits     = (wr && address == 3'd0) ? wdata_n : '0;
  assign force_bits   = (wr && address == 3'd5) ? wdata_n : '0;

  // arm's top bit rises only once irq_d holds a real post-reset sample, so an input
  // already high at reset release is not mistaken for a rising edge.
  assign rise     = irq_s & ~irq_d & {N_IRQ{arm[ARM_W-1]}};
  assign eff_pend = pend | (irq_s & ~edge_sel);
  assign act      = eff_pend & mask;

  function automatic logic [15:0] zext(input logic [N_IRQ-1:0] v);
    logic [15:0] r;
    r = '0;
    r[N_IRQ-1:0] = v;
    return r;
  endfunction

  always_comb begin
    vec_idx = 4'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (act[i]) vec_idx = 4'(i);
    end
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (address)
      3'd0: rd_mux = zext(eff_pend);
      3'd1: rd_mux = zext(mask);
      3'd2: rd_mux = zext(edge_sel);
      3'd3: rd_mux = (|act) ? {1'b1, 11'd0, vec_idx} : 16'h0000;
      3'd4: rd_mux = zext(irq_s);
      3'd6: rd_mux = tick_count;
      default: rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_s      <= '0;
      irq_d      <= '0;
      arm        <= '0;
      pend       <= '0;
      mask       <= '0;
      edge_sel   <= '0;
      tick_count <= 16'h0000;
      irq        <= 1'b0;
      readdata   <= 16'h0000;
    end else begin
      irq_s    <= irq_src;
      irq_d    <= irq_s;
      arm      <= {arm[ARM_W-2:0], 1'b1};
      pend     <= (pend & ~clr_bits) | (rise & edge_sel) | force_bits;
      irq      <= |act;
      readdata <= rd_mux;
      if (wr && address == 3'd1) mask <= wdata_n;
      if (wr && address == 3'd2) edge_sel <= wdata_n;
      // A clear always wins over a simultaneous tick.
      if (wr && address == 3'd6)
        tick_count <= 16'h0000;
      else if (rise[0])
        tick_count <= tick_count + 16'd1;
    end
  end

endmodule
